flag_reg: RTL

FLAG_REG -- requirements
Module: flag_reg

---
 rtl/flag_reg.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/flag_reg.sv
// flag_reg: ZNHC flag register (F) for an 8-bit CPU core.
//
// F holds the four condition flags in its upper nibble {Z,N,H,C}; the low
// nibble always reads zero. Flag updates commit only on the last T-cycle of
// an M-cycle (m_end). Each instruction selects one flag source and chooses
// which flags to update with a per-bit write mask. A POP AF reloads the
// flags from the stack byte and takes priority over any flag write and
// over interrupt suppression.
//
// Optional feature, enabled by defining the macro FLAG_BYPASS_EN:
//   cond_ok evaluates the flag value that is about to commit at the current
//   edge instead of the registered F. This lets a conditional branch in the
//   same M-cycle see the flags produced by the preceding operation.
//   Without the macro, cond_ok reads the registered F only.
module flag_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       m_end,
  input  logic [2:0] next_f_src,
  input  logic [3:0] f_write,
  input  logic       interrupt,
  input  logic [3:0] alu_f,
  input  logic [3:0] rot_f,
  input  logic [3:0] add16_f,
  input  logic [3:0] misc_f,
  input  logic [3:0] daa_f,
  input  logic [3:0] cpl_f,
  input  logic       pop_we,
  input  logic [7:0] pop_data,
  input  logic [1:0] cond,
  output logic [7:0] f_out,
  output logic       cond_ok,
  output logic       src_err
);

  // Bit positions of the flags inside the 4-bit flag nibble.
  localparam int unsigned Z_BIT = 3;
  localparam int unsigned C_BIT = 0;

  // Flag source select codes.
  localparam logic [2:0] SRC_ALU   = 3'b000;
  localparam logic [2:0] SRC_ROT   = 3'b001;
  localparam logic [2:0] SRC_ADD16 = 3'b010;
  localparam logic [2:0] SRC_MISC  = 3'b011;
  localparam logic [2:0] SRC_DAA   = 3'b100;
  localparam logic [2:0] SRC_CPL   = 3'b101;

  // Condition codes.
  localparam logic [1:0] CC_NZ = 2'b00;
  localparam logic [1:0] CC_Z  = 2'b01;
  localparam logic [1:0] CC_NC = 2'b10;
  localparam logic [1:0] CC_C  = 2'b11;

  logic [3:0] flags;       // registered {Z,N,H,C}
  logic [3:0] src_flags;   // candidate flags from the selected source
  logic       src_legal;   // selected source code is a real source
  logic       wr_any;      // at least one flag write enabled
  logic [3:0] next_flags;  // value F takes if this edge commits
  logic       bad_src;     // write requested through a reserved source code
  logic [3:0] eval_flags;  // flags seen by the condition evaluator

  // The low nibble of a popped byte has no storage in F; it is dropped.
  logic       unused_pop_low;
  assign unused_pop_low = ^pop_data[3:0];

  assign wr_any = |f_write;

  // Source mux. Only decoded while a write is requested, so a don't-care
  // (possibly X) select with an empty write mask never reaches the state.
  always_comb begin
    src_flags = 4'b0000;
    src_legal = 1'b0;
    if (wr_any) begin
      case (next_f_src)
        SRC_ALU:   begin src_flags = alu_f;   src_legal = 1'b1; end
        SRC_ROT:   begin src_flags = rot_f;   src_legal = 1'b1; end
        SRC_ADD16: begin src_flags = add16_f; src_legal = 1'b1; end
        SRC_MISC:  begin src_flags = misc_f;  src_legal = 1'b1; end
        SRC_DAA:   begin src_flags = daa_f;   src_legal = 1'b1; end
        SRC_CPL:   begin src_flags = cpl_f;   src_legal = 1'b1; end
        default:   begin src_flags = 4'b0000; src_legal = 1'b0; end
      endcase
    end
  end

  // Next flag value with priority POP > interrupt hold > masked write.
  // A write through a reserved source leaves F alone and is reported.
  always_comb begin
    next_flags = flags;
    bad_src    = 1'b0;
    if (pop_we) begin
      next_flags = pop_data[7:4];
    end else if (!interrupt && wr_any) begin
      if (src_legal) begin
        next_flags = (src_flags & f_write) | (flags & ~f_write);
      end else begin
        bad_src = 1'b1;
      end
    end
  end

  // F register: commits only at the end of an M-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (m_end) begin
      flags <= next_flags;
    end
  end

  // Sticky illegal-source indicator, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_err <= 1'b0;
    end else if (m_end && bad_src) begin
      src_err <= 1'b1;
    end
  end

  assign f_out = {flags, 4'b0000};

`ifdef FLAG_BYPASS_EN
  // Condition sees the value about to commit at this edge; next_flags
  // already equals F when no write or pop is pending.
  always_comb begin
    eval_flags = m_end ? next_flags : flags;
  end
`else
  // Condition sees the registered flags only.
  always_comb begin
    eval_flags = flags;
  end
`endif

  // Branch condition evaluation from Z and C.
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      CC_NZ:   cond_ok = ~eval_flags[Z_BIT];
      CC_Z:    cond_ok =  eval_flags[Z_BIT];
      CC_NC:   cond_ok = ~eval_flags[C_BIT];
      CC_C:    cond_ok =  eval_flags[C_BIT];
      default: cond_ok = 1'b0;
    endcase
  end

endmodule
